// File: rtl/psum_drain.sv
// Drains bottom-row psums of a PE array through per-column FIFOs into a single
// registered write slot, arbitrated round-robin across columns.
`ifndef PE_COL
`define PE_COL 4
`endif
`ifndef BIT_PSUM
`define BIT_PSUM 24
`endif
`ifndef BIT_VALID
`define BIT_VALID 1
`endif

module psum_drain_col #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, do_push;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && (!full || pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)              wr_ptr   <= wr_ptr + 1'b1;
      if (pop)                  rd_ptr   <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module psum_drain #(
  parameter int PE_COL     = `PE_COL,
  parameter int BIT_PSUM   = `BIT_PSUM,
  parameter int BIT_VALID  = `BIT_VALID,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = (PE_COL > 1) ? $clog2(PE_COL) : 1
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [PE_COL*BIT_PSUM-1:0]    i_Psum_In,
  input  logic [PE_COL*9-1:0]           i_Addr_P_In,
  input  logic [PE_COL*BIT_VALID-1:0]   i_Valid_P_In,
  output logic                          o_Wr_Valid,
  input  logic                          i_Wr_Ready,
  output logic [CW-1:0]                 o_Wr_Col,
  output logic [8:0]                    o_Wr_Addr,
  output logic [BIT_PSUM-1:0]           o_Wr_Data,
  output logic [PE_COL-1:0]             o_Overflow,
  output logic                          o_Empty
);
  localparam int EW = 9 + BIT_PSUM;

  logic [PE_COL-1:0]         col_vld, col_empty, col_pop;
  logic [PE_COL-1:0][EW-1:0] col_din, col_dout;
  logic [CW-1:0]             last, gnt;
  logic                      found, load;
  int                        idx;

  for (genvar c = 0; c < PE_COL; c++) begin : g_col
    assign col_vld[c] = i_Valid_P_In[BIT_VALID*c];
    assign col_din[c] = {i_Addr_P_In[9*c +: 9], i_Psum_In[BIT_PSUM*c +: BIT_PSUM]};
    assign col_pop[c] = load && found && (gnt == CW'(c));

    psum_drain_col #(.DEPTH(FIFO_DEPTH), .W(EW)) u_col (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .push     (col_vld[c]),
      .din      (col_din[c]),
      .pop      (col_pop[c]),
      .dout     (col_dout[c]),
      .empty    (col_empty[c]),
      .overflow (o_Overflow[c])
    );
  end

  // Round-robin: scan from last+1 with a single wrap; first non-empty column wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int i = 0; i < PE_COL; i++) begin
      idx = int'(last) + 1 + i;
      if (idx >= PE_COL) idx = idx - PE_COL;
      if (!found && !col_empty[idx]) begin
        found = 1'b1;
        gnt   = CW'(idx);
      end
    end
  end

  assign load    = !o_Wr_Valid || i_Wr_Ready;
  assign o_Empty = (&col_empty) && !o_Wr_Valid;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      o_Wr_Valid <= 1'b0;
      o_Wr_Col   <= '0;
      o_Wr_Addr  <= '0;
      o_Wr_Data  <= '0;
      last       <= CW'(PE_COL - 1);
    end else if (load) begin
      o_Wr_Valid <= found;
      if (found) begin
        o_Wr_Col               <= gnt;
        {o_Wr_Addr, o_Wr_Data} <= col_dout[gnt];
        last                   <= gnt;
      end
    end
  end
endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain with four columns and 4-deep column FIFOs.
module tb_psum_drain;
  localparam int PE_COL = 4;
  localparam int BP     = 24;

  logic              CLK = 1'b0;
  logic              RSTn;
  logic [PE_COL*BP-1:0] i_Psum_In;
  logic [PE_COL*9-1:0]  i_Addr_P_In;
  logic [PE_COL-1:0]    i_Valid_P_In;
  logic              o_Wr_Valid;
  logic              i_Wr_Ready;
  logic [1:0]        o_Wr_Col;
  logic [8:0]        o_Wr_Addr;
  logic [BP-1:0]     o_Wr_Data;
  logic [PE_COL-1:0] o_Overflow;
  logic              o_Empty;

  int checks = 0;
  int errors = 0;

  psum_drain #(.PE_COL(PE_COL), .BIT_PSUM(BP), .BIT_VALID(1), .FIFO_DEPTH(4)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .i_Psum_In    (i_Psum_In),
    .i_Addr_P_In  (i_Addr_P_In),
    .i_Valid_P_In (i_Valid_P_In),
    .o_Wr_Valid   (o_Wr_Valid),
    .i_Wr_Ready   (i_Wr_Ready),
    .o_Wr_Col     (o_Wr_Col),
    .o_Wr_Addr    (o_Wr_Addr),
    .o_Wr_Data    (o_Wr_Data),
    .o_Overflow   (o_Overflow),
    .o_Empty      (o_Empty)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    i_Psum_In    = '0;
    i_Addr_P_In  = '0;
    i_Valid_P_In = '0;
  endtask

  task automatic set_col(input int c, input logic v, input logic [8:0] a, input logic [BP-1:0] p);
    i_Valid_P_In[c]       = v;
    i_Addr_P_In[9*c +: 9] = a;
    i_Psum_In[BP*c +: BP] = p;
  endtask

  task automatic apply_reset();
    RSTn = 1'b0;
    clear_in();
    i_Wr_Ready = 1'b0;
    tick();
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    clear_in();
    i_Wr_Ready = 1'b1;
    tick();
    tick();
    checks++; if (o_Wr_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_Wr_Valid); end
    checks++; if (o_Wr_Col !== 2'd0) begin errors++; $display("FAIL reset_col got %0d want 0", o_Wr_Col); end
    checks++; if (o_Wr_Addr !== 9'd0) begin errors++; $display("FAIL reset_addr got %h want 0", o_Wr_Addr); end
    checks++; if (o_Wr_Data !== 24'd0) begin errors++; $display("FAIL reset_data got %h want 0", o_Wr_Data); end
    checks++; if (o_Overflow !== 4'b0000) begin errors++; $display("FAIL reset_ovf got %b want 0000", o_Overflow); end
    checks++; if (o_Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", o_Empty); end
  endtask

  task automatic test_single();
    apply_reset();
    i_Wr_Ready = 1'b1;
    set_col(2, 1'b1, 9'h005, 24'h00ABCD);
    tick();
    clear_in();
    checks++; if (o_Wr_Valid !== 1'b0) begin errors++; $display("FAIL single_latency got %b want 0", o_Wr_Valid); end
    tick();
    checks++;
    if (o_Wr_Valid !== 1'b1 || o_Wr_Col !== 2'd2 || o_Wr_Addr !== 9'h005 || o_Wr_Data !== 24'h00ABCD) begin
      errors++;
      $display("FAIL single_write got v=%b col=%0d addr=%h data=%h want v=1 col=2 addr=005 data=00abcd",
               o_Wr_Valid, o_Wr_Col, o_Wr_Addr, o_Wr_Data);
    end
    tick();
    checks++; if (o_Wr_Valid !== 1'b0 || o_Empty !== 1'b1) begin errors++; $display("FAIL single_once got v=%b empty=%b want v=0 empty=1", o_Wr_Valid, o_Empty); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    i_Wr_Ready = 1'b1;
    for (int c = 0; c < PE_COL; c++) set_col(c, 1'b1, 9'(c), 24'h000100 + 24'(c));
    tick();
    clear_in();
    for (int c = 0; c < PE_COL; c++) begin
      tick();
      checks++;
      if (o_Wr_Valid !== 1'b1 || o_Wr_Col !== 2'(c) || o_Wr_Addr !== 9'(c) || o_Wr_Data !== 24'h000100 + 24'(c)) begin
        errors++;
        $display("FAIL rr_write%0d got v=%b col=%0d addr=%h data=%h want v=1 col=%0d addr=%h data=%h",
                 c, o_Wr_Valid, o_Wr_Col, o_Wr_Addr, o_Wr_Data, c, 9'(c), 24'h000100 + 24'(c));
      end
    end
    tick();
    checks++; if (o_Empty !== 1'b1 || o_Wr_Valid !== 1'b0) begin errors++; $display("FAIL rr_empty got empty=%b v=%b want 1 0", o_Empty, o_Wr_Valid); end
  endtask

  task automatic test_overflow();
    apply_reset();
    i_Wr_Ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_col(1, 1'b1, 9'(k), 24'h000500 + 24'(k));
      tick();
    end
    clear_in();
    checks++; if (o_Overflow !== 4'b0010) begin errors++; $display("FAIL ovf_flag got %b want 0010", o_Overflow); end
    checks++;
    if (o_Wr_Valid !== 1'b1 || o_Wr_Addr !== 9'd0 || o_Wr_Data !== 24'h000500) begin
      errors++; $display("FAIL ovf_slot got v=%b addr=%h data=%h want v=1 addr=000 data=000500", o_Wr_Valid, o_Wr_Addr, o_Wr_Data);
    end
    tick();
    tick();
    checks++;
    if (o_Wr_Valid !== 1'b1 || o_Wr_Col !== 2'd1 || o_Wr_Addr !== 9'd0) begin
      errors++; $display("FAIL ovf_hold got v=%b col=%0d addr=%h want v=1 col=1 addr=000", o_Wr_Valid, o_Wr_Col, o_Wr_Addr);
    end
    i_Wr_Ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      checks++;
      if (o_Wr_Valid !== 1'b1 || o_Wr_Addr !== 9'(k) || o_Wr_Data !== 24'h000500 + 24'(k)) begin
        errors++; $display("FAIL ovf_drain%0d got v=%b addr=%h data=%h want v=1 addr=%h", k, o_Wr_Valid, o_Wr_Addr, o_Wr_Data, 9'(k));
      end
    end
    tick();
    checks++; if (o_Wr_Valid !== 1'b0 || o_Empty !== 1'b1) begin errors++; $display("FAIL ovf_dropped got v=%b empty=%b want 0 1", o_Wr_Valid, o_Empty); end
    checks++; if (o_Overflow !== 4'b0010) begin errors++; $display("FAIL ovf_sticky got %b want 0010", o_Overflow); end
  endtask

  task automatic test_ready_toggle();
    logic [1:0]  exp_col  [6];
    logic [8:0]  exp_addr [6];
    logic [1:0]  h_col;
    logic [8:0]  h_addr;
    logic [BP-1:0] h_data;
    logic        hold;
    int          n;
    for (int k = 0; k < 3; k++) begin
      exp_col[2*k]    = 2'd0; exp_addr[2*k]   = 9'h010 + 9'(k);
      exp_col[2*k+1]  = 2'd3; exp_addr[2*k+1] = 9'h030 + 9'(k);
    end
    n = 0;
    hold = 1'b0;
    h_col = '0; h_addr = '0; h_data = '0;
    apply_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 3) begin
        set_col(0, 1'b1, 9'h010 + 9'(cyc), 24'h001010 + 24'(cyc));
        set_col(3, 1'b1, 9'h030 + 9'(cyc), 24'h001030 + 24'(cyc));
      end else begin
        clear_in();
      end
      i_Wr_Ready = (cyc % 2 == 1);
      if (hold) begin
        checks++;
        if (o_Wr_Valid !== 1'b1 || o_Wr_Col !== h_col || o_Wr_Addr !== h_addr || o_Wr_Data !== h_data) begin
          errors++; $display("FAIL toggle_stable cyc%0d got v=%b col=%0d addr=%h want v=1 col=%0d addr=%h", cyc, o_Wr_Valid, o_Wr_Col, o_Wr_Addr, h_col, h_addr);
        end
      end
      if (o_Wr_Valid === 1'b1 && i_Wr_Ready) begin
        checks++;
        if (n >= 6) begin
          errors++; $display("FAIL toggle_extra got col=%0d addr=%h want no write", o_Wr_Col, o_Wr_Addr);
        end else if (o_Wr_Col !== exp_col[n] || o_Wr_Addr !== exp_addr[n] ||
                     o_Wr_Data !== 24'h001000 + 24'(exp_addr[n])) begin
          errors++; $display("FAIL toggle_write%0d got col=%0d addr=%h data=%h want col=%0d addr=%h",
                             n, o_Wr_Col, o_Wr_Addr, o_Wr_Data, exp_col[n], exp_addr[n]);
        end
        n++;
      end
      hold   = (o_Wr_Valid === 1'b1) && !i_Wr_Ready;
      h_col  = o_Wr_Col;
      h_addr = o_Wr_Addr;
      h_data = o_Wr_Data;
      tick();
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL toggle_count got %0d want 6", n); end
    checks++; if (o_Overflow !== 4'b0000) begin errors++; $display("FAIL toggle_ovf got %b want 0000", o_Overflow); end
  endtask

  task automatic test_reset_mid();
    int stale;
    apply_reset();
    i_Wr_Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_col(0, 1'b1, 9'h040 + 9'(k), 24'h004000 + 24'(k));
      set_col(2, k < 2, 9'h060 + 9'(k), 24'h006000 + 24'(k));
      tick();
    end
    clear_in();
    tick();
    checks++; if (o_Wr_Valid !== 1'b1 || o_Wr_Addr !== 9'h040) begin errors++; $display("FAIL mid_pending got v=%b addr=%h want 1 040", o_Wr_Valid, o_Wr_Addr); end
    #2;
    RSTn = 1'b0;
    #1;
    checks++;
    if (o_Wr_Valid !== 1'b0 || o_Wr_Col !== 2'd0 || o_Wr_Addr !== 9'd0 || o_Wr_Data !== 24'd0) begin
      errors++; $display("FAIL mid_clear got v=%b col=%0d addr=%h data=%h want all 0", o_Wr_Valid, o_Wr_Col, o_Wr_Addr, o_Wr_Data);
    end
    checks++; if (o_Empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", o_Empty); end
    i_Wr_Ready = 1'b1;
    tick();
    #2;
    RSTn = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_Wr_Valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got %0d writes want 0", stale); end
    checks++; if (o_Empty !== 1'b1) begin errors++; $display("FAIL mid_release_empty got %b want 1", o_Empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_ready_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
